icache: RTL
===========

# icache

Direct-mapped instruction cache between the instruction fetcher and the memory controller. It accepts one fetch address per cycle from the fetcher and returns the 32-bit instruction one cycle later on a hit. On a miss it refills a 4-word line from the memory controller, one word per transaction, then returns the instruction. A branch-mispredict flush from the ROB squashes any in-flight response so that stale instructions never reach the fetcher.

## Interface
Parameters:
- INDEX_BITS, 6: line index width; the cache holds 2^INDEX_BITS lines of 4 words each (16 B per line).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rdy  input  1  global enable; when low, all state is frozen.
- IF_pc_sgn  input  1  fetch request valid.
- IF_pc  input  32  fetch address; bits [1:0] are ignored.
- IF_ins_sgn  output  1  instruction valid, a one-cycle pulse per accepted request.
- IF_ins  output  32  instruction word.
- ROB_jp_wrong  input  1  mispredict flush.
- MC_req  output  1  memory read request, level-held.
- MC_addr  output  32  word-aligned read address.
- MC_done  input  1  read-word-complete pulse.
- MC_data  input  32  word returned with MC_done.

## Operation
- Address split:
  - offset = pc[3:2]
  - index = pc[4+INDEX_BITS-1:4]
  - tag = pc[31:4+INDEX_BITS]
- Storage per line: 1 valid bit, a tag, and 4 data words.
- States:
  - IDLE accepts a request when IF_pc_sgn=1 and rdy=1, and latches pc into req_pc.
    - Hit (valid and tag match): the word is registered and presented next cycle; the state stays IDLE.
    - Miss: go to REFILL with cnt=0.
  - REFILL:
    - MC_req=1 and MC_addr={req_pc[31:4], cnt, 2'b00}.
    - On MC_done, MC_data is written into word cnt of the line buffer and cnt increments.
    - MC_addr advances the cycle after each MC_done; MC_req stays high between words.
    - On the 4th MC_done: write tag, data and valid=1 to the array; drop MC_req the next cycle; go to IDLE.
    - In the cycle after the 4th MC_done, present word req_pc[3:2] unless the refill was squashed.
    - New requests are ignored during REFILL; the fetcher holds its request until IF_ins_sgn.
- Flush, when ROB_jp_wrong=1 in cycle t:
  - IF_ins_sgn is gated to 0 in cycle t.
  - A refill in progress is marked squashed. It completes the line fill, but no response is produced.
  - A request presented in cycle t itself, in IDLE, is accepted normally because it carries the redirect target.
- rdy=0:
  - All registers hold, including counters, state and the line buffer.
  - IF_ins_sgn is gated to 0; a pending response is re-presented once rdy returns.
  - MC_req and MC_addr hold their values.
- Reset:
  - Clears all valid bits and sets state to IDLE, cnt=0 and squash=0.
  - Outputs: IF_ins_sgn=0, IF_ins=0, MC_req=0, MC_addr=0.
  - rst asserted mid-REFILL aborts the refill; MC_req is 0 the next cycle and the partial line is discarded.
- Fetched instructions are never invalidated; there is no self-modifying-code support.

## Timing
- Hit latency is 1 cycle: request in cycle t gives IF_ins_sgn=1 in t+1.
- Back-to-back hits run at 1 per cycle. A request presented in the same cycle as a response is accepted.
- Miss latency: MC_req rises in t+1. If the 4th MC_done falls in cycle d, the response is in d+1 and IDLE accepts a new request in d+1.
- A miss at a set's index replaces its line in the same cycle the response appears. A same-line request in d+1 must hit.
- IF_ins_sgn is never high for two consecutive cycles for the same request.
- MC_addr is stable whenever MC_req=1, except in the cycle after an MC_done.

## Test plan
- Cold miss, with MC_done 3 cycles after each address:
  - Request pc=0x00001008.
  - MC_addr must step 0x1000, 0x1004, 0x1008, 0x100C.
  - Then IF_ins_sgn=1 with the word returned for 0x1008.
  - Then MC_req=0.
- Sequential hits: after the fill, requests 0x1000, 0x1004, 0x100C in consecutive cycles must give 3 consecutive responses with 1-cycle latency and no MC_req.
- Conflict eviction:
  - Fill 0x1000, then request 0x1400 (same index at INDEX_BITS=6) and expect a miss with a refill from 0x1400.
  - Re-requesting 0x1000 must miss again.
- Flush mid-refill:
  - Assert ROB_jp_wrong during the 2nd MC_done.
  - All 4 words must still be fetched, with no IF_ins_sgn.
  - A later request to the same line must hit.
- Flush on the response cycle: a hit request in t with ROB_jp_wrong in t+1 must give IF_ins_sgn=0 in t+1, while a redirect request in t+1 returns in t+2.
- rdy and reset:
  - Drop rdy for 5 cycles mid-REFILL: state, MC_addr and cnt must hold, and the refill completes normally afterwards.
  - Assert rst mid-REFILL: MC_req=0 the next cycle, and the previously filled line misses afterwards.

Source files
------------

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module   : icache
//  Purpose  : Direct-mapped instruction cache, 4-word lines, refilled one
//             word per memory transaction; ROB flush squashes responses.
//  Revision : 1.0  initial release
// ============================================================================
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        IF_pc_sgn,
  input  logic [31:0] IF_pc,
  output logic        IF_ins_sgn,
  output logic [31:0] IF_ins,
  input  logic        ROB_jp_wrong,
  output logic        MC_req,
  output logic [31:0] MC_addr,
  input  logic        MC_done,
  input  logic [31:0] MC_data
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  state_t state, state_next;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_arr  [LINES];
  logic [127:0]        data_arr [LINES];

  logic [31:2] req_pc;
  logic [1:0]  cnt;
  logic        squash;
  logic [31:0] line_buf [4];
  logic        resp_valid;
  logic [31:0] resp_data;

  logic                  unused_pc_bits;
  logic [INDEX_BITS-1:0] lk_index;
  logic [TAG_BITS-1:0]   lk_tag;
  logic [127:0]          lk_line;
  logic                  hit;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic [127:0]          fill_line;
  logic                  fill_last;

  assign unused_pc_bits = ^IF_pc[1:0];

  assign lk_index = IF_pc[4+INDEX_BITS-1:4];
  assign lk_tag   = IF_pc[31:4+INDEX_BITS];
  assign lk_line  = data_arr[lk_index];
  assign hit      = valid[lk_index] && (tag_arr[lk_index] == lk_tag);

  assign fill_index = req_pc[4+INDEX_BITS-1:4];
  assign fill_tag   = req_pc[31:4+INDEX_BITS];
  // The 4th word goes straight from the bus into the array write.
  assign fill_line  = {MC_data, line_buf[2], line_buf[1], line_buf[0]};
  assign fill_last  = (state == REFILL) && MC_done && (cnt == 2'd3);

  // A response is hidden while frozen or flushed; it stays pending under rdy=0.
  assign IF_ins_sgn = resp_valid && rdy && !ROB_jp_wrong;
  assign IF_ins     = resp_data;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else if (rdy) state <= state_next;
  end

  always_comb begin
    state_next = state;
    MC_req     = 1'b0;
    MC_addr    = '0;
    case (state)
      IDLE: begin
        if (IF_pc_sgn && !hit) state_next = REFILL;
      end
      REFILL: begin
        MC_req  = 1'b1;
        MC_addr = {req_pc[31:4], cnt, 2'b00};
        if (MC_done && (cnt == 2'd3)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= '0;
      req_pc     <= '0;
      cnt        <= 2'd0;
      squash     <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else if (rdy) begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (IF_pc_sgn) begin
            req_pc <= IF_pc[31:2];
            if (hit) begin
              resp_valid <= 1'b1;
              resp_data  <= lk_line[{IF_pc[3:2], 5'b0} +: 32];
            end else begin
              cnt    <= 2'd0;
              squash <= 1'b0;
            end
          end
        end
        REFILL: begin
          if (ROB_jp_wrong) squash <= 1'b1;
          if (MC_done) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              valid[fill_index] <= 1'b1;
              // A flush landing on the final word squashes this response too.
              if (!(squash || ROB_jp_wrong)) begin
                resp_valid <= 1'b1;
                resp_data  <= fill_line[{req_pc[3:2], 5'b0} +: 32];
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && (state == REFILL) && MC_done) line_buf[cnt] <= MC_data;
    if (!rst && rdy && fill_last) begin
      tag_arr[fill_index]  <= fill_tag;
      data_arr[fill_index] <= fill_line;
    end
  end

endmodule
`default_nettype wire
